// File: rtl/program_loader.sv
// Frame-based instruction-memory loader: hunts for a sync byte, takes a length,
// writes the payload into instruction memory and releases the CPU from reset
// only once the frame checksum verifies.
module program_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [7:0]        SYNC_BYTE = 8'hA5,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [7:0]        len_r;
  logic [7:0]        idx_r;
  logic [7:0]        sum_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [7:0]        imem_wdata_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              err_r;
  logic              accept_s;
  logic              chk_ok_s;
  logic              last_data_s;

  // Modulo-256 running checksum step.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    sum8 = a + b;
  endfunction

  // Ready is withheld in DONE and while reset is asserted.
  assign in_ready    = reset_n && (state_r != S_DONE);
  assign accept_s    = in_valid && in_ready;
  assign chk_ok_s    = (sum8(sum_r, in_data) == 8'd0);
  assign last_data_s = (idx_r == (len_r - 8'd1));

  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign err        = err_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_SYNC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a sync byte seen after LEN is ordinary data.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_SYNC: begin
        if (accept_s && (in_data == SYNC_BYTE)) state_next_s = S_LEN;
        else                                    state_next_s = S_SYNC;
      end
      S_LEN: begin
        if (accept_s) state_next_s = (in_data == 8'd0) ? S_SYNC : S_DATA;
        else          state_next_s = S_LEN;
      end
      S_DATA: begin
        if (accept_s && last_data_s) state_next_s = S_CHK;
        else                         state_next_s = S_DATA;
      end
      S_CHK: begin
        if (accept_s) state_next_s = chk_ok_s ? S_DONE : S_SYNC;
        else          state_next_s = S_CHK;
      end
      S_DONE: begin
        if (reload) state_next_s = S_SYNC;
        else        state_next_s = S_DONE;
      end
      default: state_next_s = S_SYNC;
    endcase
  end

  // Frame datapath, write strobe one cycle after each payload accept, status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_r        <= 8'd0;
      idx_r        <= 8'd0;
      sum_r        <= 8'd0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= 8'd0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      imem_we_r <= 1'b0;
      if (accept_s) begin
        case (state_r)
          S_SYNC: begin
            if (in_data == SYNC_BYTE) begin
              err_r <= 1'b0;
              sum_r <= 8'd0;
            end
          end
          S_LEN: begin
            len_r <= in_data;
            idx_r <= 8'd0;
            if (in_data == 8'd0) err_r <= 1'b1;
          end
          S_DATA: begin
            imem_we_r    <= 1'b1;
            imem_addr_r  <= BASE_ADDR + ADDR_W'(idx_r);
            imem_wdata_r <= in_data;
            sum_r        <= sum8(sum_r, in_data);
            idx_r        <= idx_r + 8'd1;
          end
          S_CHK: begin
            if (chk_ok_s) begin
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              err_r <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
      if ((state_r == S_DONE) && reload) begin
        cpu_hold_r <= 1'b1;
        done_r     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader with a frame-level reference model.
module tb_program_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] BASE = 8'hFE;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       reload = 1'b0;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  frame_q [$];
  logic [15:0] got_q   [$];
  logic [15:0] exp_q   [$];

  program_loader #(.ADDR_W(8), .SYNC_BYTE(SYNC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it (bounded wait).
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int wait_c;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    wait_c   = 0;
    while (!in_ready && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    if (gaps) in_valid = 1'b0;
  endtask

  // Reference model: interpret the byte stream by the framing rules, drive it, compare.
  task automatic run_frame(input bit gaps);
    int i;
    int sync_pos;
    int n;
    logic [7:0] sum;
    bit exp_done;
    bit exp_err;
    exp_q.delete();
    got_q.delete();
    i = 0;
    while (i < frame_q.size() && frame_q[i] != SYNC) i++;
    sync_pos = i;
    n = frame_q[i + 1];
    sum = 8'd0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0) begin
      exp_err = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({BASE + 8'(k), frame_q[i + 2 + k]});
        sum = sum + frame_q[i + 2 + k];
      end
      sum = sum + frame_q[i + 2 + n];
      if (sum == 8'd0) exp_done = 1'b1;
      else             exp_err  = 1'b1;
    end
    for (int j = 0; j < frame_q.size(); j++) begin
      send_byte(frame_q[j], gaps);
      if (j == sync_pos) check("err_clr_on_sync", {31'd0, err}, 32'd0);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("n_strobes", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check("strobe", {16'd0, got_q[k]}, {16'd0, exp_q[k]});
    check("done", {31'd0, done}, {31'd0, exp_done});
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
    check("in_ready", {31'd0, in_ready}, {31'd0, !exp_done});
    if (exp_done) begin
      in_valid = 1'b1;
      in_data  = SYNC;
      repeat (3) @(negedge clk);
      check("done_not_consumed", {31'd0, done}, 32'd1);
      check("done_no_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      check("reload_done", {31'd0, done}, 32'd0);
      check("reload_hold", {31'd0, cpu_hold}, 32'd1);
      check("reload_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic set_frame(input logic [7:0] a [], input int len);
    frame_q.delete();
    for (int k = 0; k < len; k++) frame_q.push_back(a[k]);
  endtask

  // Random frame: garbage prefix (never the sync byte), length, payload, checksum.
  task automatic rand_frame();
    int n;
    logic [7:0] sum;
    logic [7:0] b;
    frame_q.delete();
    repeat ($urandom_range(0, 3)) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      frame_q.push_back(b);
    end
    frame_q.push_back(SYNC);
    n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
    frame_q.push_back(8'(n));
    sum = 8'd0;
    for (int k = 0; k < n; k++) begin
      b = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom_range(0, 255));
      frame_q.push_back(b);
      sum = sum + b;
    end
    if (n != 0) begin
      b = 8'd0 - sum;
      if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
      frame_q.push_back(b);
    end
  endtask

  initial begin
    logic [7:0] f [];
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", {24'd0, imem_wdata}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Directed frames (addresses wrap from FE).
    f = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
    set_frame(f, 6); run_frame(1'b0);
    f = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    set_frame(f, 5); run_frame(1'b1);
    f = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h7F, 8'h81};
    set_frame(f, 7); run_frame(1'b1);
    f = '{8'hA5, 8'h00};
    set_frame(f, 2); run_frame(1'b1);
    f = '{8'hA5, 8'h03, 8'h01, 8'h01, 8'h01, 8'hFD};
    set_frame(f, 6); run_frame(1'b0);

    // Maximum-length frame.
    frame_q.delete();
    frame_q.push_back(SYNC);
    frame_q.push_back(8'd255);
    begin
      logic [7:0] s;
      logic [7:0] b;
      s = 8'd0;
      for (int k = 0; k < 255; k++) begin
        b = 8'($urandom_range(0, 255));
        frame_q.push_back(b);
        s = s + b;
      end
      frame_q.push_back(8'd0 - s);
    end
    run_frame(1'b0);

    // Reset in the middle of the payload.
    got_q.delete();
    send_byte(SYNC, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_n_strobes", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("mid_rst_strobe0", {16'd0, got_q[0]}, {16'd0, BASE, 8'h11});
      check("mid_rst_strobe1", {16'd0, got_q[1]}, {16'd0, BASE + 8'd1, 8'h22});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    f = '{8'hA5, 8'h02, 8'h40, 8'h41, 8'h7F};
    set_frame(f, 5); run_frame(1'b1);

    // Randomized frames.
    for (int r = 0; r < 40; r++) begin
      rand_frame();
      run_frame($urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
